irq_pending_latch: RTL and testbench

Collects eight asynchronous request lines and holds them as a registered pending vector. The vector feeds the 8-bit priority encoder directly; the encoder's 3-bit position comes back as an acknowledge that clears the serviced bit. The block sits immediately upstream of the encoder in the interrupt path. It provides input synchronisation, edge capture, per-line masking and overflow flags.

---
 rtl/irq_pending_latch.sv | 82 ++++++++
 tb/tb_irq_pending_latch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Synchronises eight request lines and latches rising edges as a pending vector; ack/clr_all clear it.
// Build option IRQ_EDGE_CAPTURE_EN: defined = edge capture + overflow; undefined = level mirror of the synchronised lines.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic [2:0] ack_pos,
  input  logic       clr_all,
  output logic [7:0] pending,
  output logic       any_pending,
  output logic [7:0] overflow
);

  logic [SYNC_STAGES-1:0][7:0] r_sync;
  logic [7:0]                  w_sync;
  logic [7:0]                  r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef IRQ_EDGE_CAPTURE_EN
  logic [7:0] r_sync_d;
  logic [7:0] r_overflow;
  logic [7:0] w_rise;
  logic [7:0] w_ack_dec;

  assign w_rise    = w_sync & ~r_sync_d;
  assign w_ack_dec = ack ? (8'd1 << ack_pos) : 8'd0;

  // A rise beats a same-cycle ack of that bit; an acked bit never flags overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_d   <= 8'h00;
      r_pend     <= 8'h00;
      r_overflow <= 8'h00;
    end else begin
      r_sync_d <= w_sync;
      if (clr_all) begin
        r_pend     <= 8'h00;
        r_overflow <= 8'h00;
      end else begin
        r_pend     <= w_rise | (r_pend & ~w_ack_dec);
        r_overflow <= r_overflow | (w_rise & r_pend & ~w_ack_dec);
      end
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ack;

  assign w_unused_ack = ^{ack, ack_pos};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 8'h00;
    end else begin
      r_pend <= clr_all ? 8'h00 : w_sync;
    end
  end

  assign overflow = 8'h00;
`endif

  assign pending     = r_pend & mask;
  assign any_pending = |pending;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch; expectations follow whichever build mode is compiled.
module tb_irq_pending_latch;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_pos;
  logic       clr_all;
  logic [7:0] pending;
  logic       any_pending;
  logic [7:0] overflow;

  int checks = 0;
  int errors = 0;

  irq_pending_latch #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .ack(ack),
    .ack_pos(ack_pos), .clr_all(clr_all), .pending(pending),
    .any_pending(any_pending), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 8'hFF; mask = 8'hFF; ack = 1'b0; ack_pos = 3'd0; clr_all = 1'b0;
    tick(2);
    chk("reset_pending", pending, 8'h00);
    chk("reset_any", {7'd0, any_pending}, 8'h00);
    chk("reset_overflow", overflow, 8'h00);
    rst_n = 1'b1;
    tick(2);
    chk("post_reset_edge2", pending, 8'h00);
    tick(1);
    chk("post_reset_edge3", pending, 8'hFF);
    chk("post_reset_ovf", overflow, 8'h00);
    irq_in = 8'h00;
    tick(3);
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    chk("clr_idle", pending, 8'h00);

`ifdef IRQ_EDGE_CAPTURE_EN
    // Masked single event stays latched and appears when unmasked.
    mask = 8'hDF; irq_in = 8'h20;
    tick(2);
    irq_in = 8'h00;
    tick(3);
    chk("masked_pending", pending, 8'h00);
    chk("masked_any", {7'd0, any_pending}, 8'h00);
    mask = 8'hFF;
    #1;
    chk("unmask_pending", pending, 8'h20);
    chk("unmask_any", {7'd0, any_pending}, 8'h01);
    ack = 1'b1; ack_pos = 3'd1;
    tick(1);
    ack = 1'b0;
    chk("ack_nonpending", pending, 8'h20);
    ack = 1'b1; ack_pos = 3'd5;
    tick(1);
    ack = 1'b0;
    chk("ack_bit5", pending, 8'h00);

    // Multi-line service, lowest index first.
    irq_in = 8'h94;
    tick(3);
    chk("multi_latch", pending, 8'h94);
    ack = 1'b1; ack_pos = 3'd2;
    tick(1);
    chk("multi_ack2", pending, 8'h90);
    ack_pos = 3'd4;
    tick(1);
    chk("multi_ack4", pending, 8'h80);
    ack_pos = 3'd7;
    tick(1);
    chk("multi_ack7", pending, 8'h00);
    chk("multi_any", {7'd0, any_pending}, 8'h00);
    ack = 1'b0; irq_in = 8'h00;
    tick(3);

    // Set beats simultaneous ack; acked bit does not overflow.
    irq_in = 8'h08;
    tick(2);
    irq_in = 8'h00;
    tick(3);
    chk("bit3_latch", pending, 8'h08);
    irq_in = 8'h08;
    tick(2);
    ack = 1'b1; ack_pos = 3'd3;
    tick(1);
    ack = 1'b0;
    chk("set_vs_ack_pend", pending, 8'h08);
    chk("set_vs_ack_ovf", overflow, 8'h00);
    irq_in = 8'h00;
    tick(3);
    irq_in = 8'h08;
    tick(2);
    irq_in = 8'h00;
    tick(1);
    chk("ovf_set", overflow, 8'h08);
    tick(3);
    chk("ovf_sticky", overflow, 8'h08);

    // clr_all dominates ack and a concurrent rise.
    irq_in = 8'h01;
    tick(2);
    clr_all = 1'b1; ack = 1'b1; ack_pos = 3'd0;
    tick(1);
    clr_all = 1'b0; ack = 1'b0;
    chk("clr_dom_pend", pending, 8'h00);
    chk("clr_dom_ovf", overflow, 8'h00);
    irq_in = 8'h00;
    tick(3);
    chk("clr_dom_no_retrigger", pending, 8'h00);
`else
    irq_in = 8'h02;
    tick(3);
    chk("level_set", pending, 8'h02);
    ack = 1'b1; ack_pos = 3'd1;
    tick(1);
    ack = 1'b0;
    chk("level_ack_ignored", pending, 8'h02);
    chk("level_ovf", overflow, 8'h00);
    mask = 8'hFD;
    #1;
    chk("level_masked", pending, 8'h00);
    mask = 8'hFF;
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    chk("level_clr", pending, 8'h00);
    tick(1);
    chk("level_after_clr", pending, 8'h02);
    irq_in = 8'h00;
    tick(2);
    chk("level_fall_2", pending, 8'h02);
    tick(1);
    chk("level_fall_3", pending, 8'h00);
    chk("level_any", {7'd0, any_pending}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
